// File: rtl/serial_cla_adder32.sv
// serial_cla_adder32: 32-bit adder/subtractor that reuses one 8-bit
// carry-lookahead slice over four consecutive cycles, least significant
// byte first. The byte carry is held in a register between slices.

// 8-bit carry-lookahead slice: sum, group generate/propagate, and the
// carry into bit 7 (needed for signed-overflow detection).
module eightcla (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       gg,
    output logic       pg,
    output logic       cmsb
);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign s    = p ^ c;
    assign pg   = &p;
    assign cmsb = c[7];

    // Two-level lookahead: every carry is a flat sum of generate/propagate products.
    always_comb begin : lookahead
        logic prod;
        prod = 1'b0;
        c    = '0;
        gg   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prod = cin;
            for (int k = 0; k < i; k++) prod = prod & p[k];
            c[i] = prod;
            for (int j = 0; j < i; j++) begin
                prod = g[j];
                for (int k = j + 1; k < i; k++) prod = prod & p[k];
                c[i] = c[i] | prod;
            end
        end
        for (int j = 0; j < 8; j++) begin
            prod = g[j];
            for (int k = j + 1; k < 8; k++) prod = prod & p[k];
            gg = gg | prod;
        end
    end
endmodule

module serial_cla_adder32 (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_result,
    output logic        carry_out,
    output logic        overflow,
    output logic        isZero
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        carry;
    logic [1:0]  idx;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [7:0]  s_byte;
    logic        gg;
    logic        pg;
    logic        cmsb;
    logic        cnext;
    logic        accept;

    function automatic logic is_zero32(input logic [31:0] v);
        return (v == 32'd0);
    endfunction

    // A new operation is taken only when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    assign a_byte = opa[{idx, 3'b000} +: 8];
    assign b_byte = opb[{idx, 3'b000} +: 8];
    assign cnext  = gg | (pg & carry);

    eightcla u_cla (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .s    (s_byte),
        .gg   (gg),
        .pg   (pg),
        .cmsb (cmsb)
    );

    // Operand capture; subtraction folds in as B inverted plus carry-in 1.
    always_ff @(posedge clock) begin
        if (accept) begin
            opa <= data_operandA;
            opb <= data_operandB ^ {32{sub}};
        end
    end

    // Control FSM with registered busy/done and result/flag registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= 2'd0;
            carry       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_result <= 32'd0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            isZero      <= 1'b0;
        end else if (accept) begin
            state       <= ADD;
            idx         <= 2'd0;
            carry       <= sub;
            data_result <= 32'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            case (state)
                ADD: begin
                    data_result[{idx, 3'b000} +: 8] <= s_byte;
                    carry <= cnext;
                    idx   <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        carry_out <= cnext;
                        overflow  <= cmsb ^ cnext;
                        isZero    <= is_zero32({s_byte, data_result[23:0]});
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cla_adder32.sv
// Directed and randomized checks for serial_cla_adder32.
module tb_serial_cla_adder32;
    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        sub;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] data_result;
    logic        carry_out;
    logic        overflow;
    logic        isZero;

    int n_assert = 0;
    int n_fail   = 0;

    serial_cla_adder32 dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .sub           (sub),
        .data_operandA (opA),
        .data_operandB (opB),
        .busy          (busy),
        .done          (done),
        .data_result   (data_result),
        .carry_out     (carry_out),
        .overflow      (overflow),
        .isZero        (isZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 33-bit reference: sum of A and (B xor sub) plus sub.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic c, output logic v, output logic z);
        logic [32:0] t;
        logic [31:0] bb;
        bb = b ^ {32{s}};
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
        r  = t[31:0];
        c  = t[32];
        v  = (a[31] == bb[31]) && (r[31] != a[31]);
        z  = (r == 32'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic ec, input logic ev, input logic ez,
                         input string tag);
        int   lat;
        logic got;
        @(negedge clock);
        start = 1'b1; opA = a; opB = b; sub = s;
        @(posedge clock); #1;
        start = 1'b0; opA = ~a; opB = b ^ 32'h5A5A5A5A; sub = ~s;
        check({tag, ".busy"}, busy, 1);
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clock); #1;
            lat++;
            got = done;
        end
        check({tag, ".latency"}, lat, 4);
        check({tag, ".result"}, data_result, er);
        check({tag, ".carry"}, carry_out, ec);
        check({tag, ".ovf"}, overflow, ev);
        check({tag, ".zero"}, isZero, ez);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        rs, ec, ev, ez, saw_done;

        resetn = 1'b0; start = 1'b0; sub = 1'b0; opA = '0; opB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.result", data_result, 0);
        check("rst.flags", {carry_out, overflow, isZero}, 0);
        @(negedge clock); resetn = 1'b1;

        do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, "add_ff_1");
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, "add_ovf");
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "add_wrap");
        do_op(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
        do_op(32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, "sub_7_5");
        do_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, "sub_0_0");
        do_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");

        // Results hold after returning to idle.
        @(posedge clock); #1;
        check("hold.done", done, 0);
        check("hold.busy", busy, 0);
        check("hold.result", data_result, 32'h7FFFFFFF);
        check("hold.flags", {carry_out, overflow, isZero}, 3'b110);

        // start held for 10 cycles: accepted at cycles 0 and 5 only.
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            start = (k < 10);
            opA   = 32'h01010101 * (k + 1);
            opB   = 32'h00000010 * (k + 1);
            sub   = k[0];
            @(posedge clock); #1;
            check("held.busy", busy, ((k >= 0 && k <= 3) || (k >= 5 && k <= 8)) ? 1 : 0);
            if (k == 4) begin
                check("held.done0", done, 1);
                check("held.res0", data_result, 32'h01010111);
                check("held.flags0", {carry_out, overflow, isZero}, 3'b000);
            end else if (k == 9) begin
                check("held.done1", done, 1);
                check("held.res1", data_result, 32'h060605A6);
                check("held.flags1", {carry_out, overflow, isZero}, 3'b100);
            end else begin
                check("held.nodone", done, 0);
            end
        end
        start = 1'b0;

        // Reset during the second ADD cycle aborts the operation.
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, "pre_rst");
        @(negedge clock);
        start = 1'b1; opA = 32'h12345678; opB = 32'h11111111; sub = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        check("abort.result", data_result, 0);
        check("abort.flags", {carry_out, overflow, isZero}, 0);
        check("abort.ctrl", {busy, done}, 0);
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            saw_done = saw_done | done;
        end
        check("abort.nodone", saw_done, 0);
        @(negedge clock); resetn = 1'b1;
        do_op(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0, "post_rst");

        // Randomized operations against the 33-bit reference.
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n % 16 == 0) rb = ra;
            model(ra, rb, rs, er, ec, ev, ez);
            do_op(ra, rb, rs, er, ec, ev, ez, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
